fp_special_result_merge: RTL and testbench
==========================================

Name: fp_special_result_merge

Overview:
- Sits directly downstream of the FMA special-case detector and alongside the FMA arithmetic datapath.
- At issue time it captures the detector's flags and the operand signs into an in-order FIFO.
- When the datapath later delivers a result, it pops the matching entry and overrides the result with a canonical NaN, infinity or signed zero where IEEE-754 requires it.
- The final result is presented through a registered valid/ready output.

Parameters:
- WIDTH, 32, total FP word width.
- EXP_WIDTH, 8, exponent field width.
- SIG_WIDTH, 23, stored significand width; WIDTH = 1 + EXP_WIDTH + SIG_WIDTH.
- DEPTH, 4, flag FIFO entries (power of two, >= 2); must be >= number of ops in flight in the datapath.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- iss_valid  in  1  op issued to datapath this cycle; flags below are valid
- iss_ready  out  1  FIFO can accept (count < DEPTH)
- aIsPZero, aIsNZero, bIsPZero, bIsNZero, cIsPZero, cIsNZero  in  1 each  detector zero flags
- setResultNaN, setResultPInf, setResultNInf  in  1 each  detector NaN/Inf flags
- prod_sign  in  1  sign(A) xor sign(B)
- c_sign  in  1  sign(C)
- dp_valid  in  1  datapath result valid
- dp_result  in  WIDTH  datapath rounded result
- dp_ready  out  1  block consumes dp_result this cycle
- out_valid  out  1  final result valid
- out_result  out  WIDTH  final result
- out_special  out  1  out_result came from the override path
- out_ready  in  1  consumer accepts

Behaviour:
- Reset (synchronous, rst=1 at clk edge): FIFO rd/wr pointers and count = 0, out_valid = 0, out_result = 0, out_special = 0 (and out_invalid = 0 when the optional feature is built). Reset mid-operation discards all queued entries and any held output.
- Push: iss_valid & iss_ready writes an 11-bit entry {9 flags, prod_sign, c_sign}. iss_valid while full is ignored; the issuer must not assert it.
- iss_ready = (count != DEPTH). There is no same-cycle push/pop pass-through when full.
- dp_ready = (count != 0) & (~out_valid | out_ready).
- Pop: occurs on dp_valid & dp_ready; the head entry is resolved combinationally against dp_result.
- Output register loads on pop. out_valid rises the next cycle, so latency is 1 cycle from dp accept.
- Minimum issue-to-out_valid latency is 2 cycles; there is no bypass of an empty FIFO.
- out_valid, out_result and out_special hold stable while out_valid & ~out_ready.
- If out_valid & out_ready with no pop, out_valid clears. If out_valid & out_ready with a pop, the new value loads (full throughput).
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- dp_valid with an empty FIFO is a protocol error: dp_ready stays low and nothing is popped.
- Resolution priority for the head entry, with pz = aZ|bZ, where xZ = xIsPZero|xIsNZero, and inf = setResultPInf|setResultNInf:
  1. NaN if setResultNaN, or (setResultPInf & setResultNInf), or (inf & pz). Result = canonical qNaN {0, all-ones exp, 1, zeros}, out_special = 1.
  2. Else if setResultPInf: +Inf {0, ones, zeros}, out_special = 1.
  3. Else if setResultNInf: -Inf {1, ones, zeros}, out_special = 1.
  4. Else if pz & (cIsPZero|cIsNZero): signed zero with sign = prod_sign & c_sign (round-to-nearest rule), out_special = 1.
  5. Else dp_result unchanged, out_special = 0.

Optional Feature:
- Macro: FP_SPECIAL_INVALID_FLAG_EN.
- When defined: adds port out_invalid (out, 1), registered with out_result. It is 1 only when rule 1 fired due to (setResultPInf & setResultNInf) or (inf & pz); a NaN propagated from setResultNaN alone gives 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - canonical constants QNAN, PINF, NINF, PZERO, NZERO, derived from WIDTH/EXP_WIDTH/SIG_WIDTH;
  - the FIFO entry typedef (flag struct, 11 bits);
  - the flag-bit index constants.
- One sub-module: fp_special_flag_fifo (DEPTH-entry synchronous FIFO with count, push/pop, full/empty).
- Resolution logic and output register stay in the top.

Test Plan (WIDTH=32):
- Issue setResultNaN=1; dp_result=32'h3F800000 -> out_result=32'h7FC00000, out_special=1, out_valid 1 cycle after dp accept.
- Issue aIsPZero=1, setResultPInf=1 (0 x Inf) -> 32'h7FC00000; with the macro defined, out_invalid=1.
- Issue setResultNInf=1 only; dp_result=32'h12345678 -> 32'hFF800000, out_special=1.
- Issue bIsNZero=1, cIsNZero=1, prod_sign=1, c_sign=1 -> 32'h80000000. Repeat with c_sign=0 -> 32'h00000000.
- Issue 4 ops with dp_valid=0 -> iss_ready=0 after the 4th push. Then return 4 results with out_ready toggling -> outputs in issue order, each result held stable while out_ready=0, no loss or duplication.
- Push 3 ops, assert rst for 1 cycle mid-stream -> next cycle out_valid=0, dp_ready=0, iss_ready=1; a subsequent issue resolves with no stale entry.

Source files
------------

// File: rtl/fp_special_result_merge_pkg.sv
// fp_special_result_merge_pkg: canonical FP constants, flag FIFO entry type and flag bit indices.
package fp_special_result_merge_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_EXP_WIDTH = 8;
  localparam int FP_SIG_WIDTH = 23;
  localparam logic [FP_WIDTH-1:0] QNAN = {1'b0, {FP_EXP_WIDTH{1'b1}}, 1'b1, {(FP_SIG_WIDTH-1){1'b0}}};
  localparam logic [FP_WIDTH-1:0] PINF = {1'b0, {FP_EXP_WIDTH{1'b1}}, {FP_SIG_WIDTH{1'b0}}};
  localparam logic [FP_WIDTH-1:0] NINF = {1'b1, {FP_EXP_WIDTH{1'b1}}, {FP_SIG_WIDTH{1'b0}}};
  localparam logic [FP_WIDTH-1:0] PZERO = '0;
  localparam logic [FP_WIDTH-1:0] NZERO = {1'b1, {(FP_WIDTH-1){1'b0}}};
  localparam int FLAG_W = 11;
  localparam int F_NAN = 10;
  localparam int F_PINF = 9;
  localparam int F_NINF = 8;
  localparam int F_A_PZ = 7;
  localparam int F_A_NZ = 6;
  localparam int F_B_PZ = 5;
  localparam int F_B_NZ = 4;
  localparam int F_C_PZ = 3;
  localparam int F_C_NZ = 2;
  localparam int F_PROD_SIGN = 1;
  localparam int F_C_SIGN = 0;
  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
    logic a_pz;
    logic a_nz;
    logic b_pz;
    logic b_nz;
    logic c_pz;
    logic c_nz;
    logic prod_sign;
    logic c_sign;
  } flags_t;
endpackage

// File: rtl/fp_special_result_merge_flag_fifo.sv
// fp_special_flag_fifo: in-order DEPTH-entry flag FIFO with occupancy count; pushes when full and pops when empty are dropped.
module fp_special_flag_fifo
  import fp_special_result_merge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  flags_t mem_q [DEPTH];
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_ptr_q];
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wr_ptr_q] <= din;
endmodule

// File: rtl/fp_special_result_merge.sv
// fp_special_result_merge: overrides FMA results with canonical NaN/Inf/signed-zero from queued detector flags.
// Optional out_invalid port under `FP_SPECIAL_INVALID_FLAG_EN.
module fp_special_result_merge
  import fp_special_result_merge_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int EXP_WIDTH = FP_EXP_WIDTH,
  parameter int SIG_WIDTH = FP_SIG_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic             aIsPZero,
  input  logic             aIsNZero,
  input  logic             bIsPZero,
  input  logic             bIsNZero,
  input  logic             cIsPZero,
  input  logic             cIsNZero,
  input  logic             setResultNaN,
  input  logic             setResultPInf,
  input  logic             setResultNInf,
  input  logic             prod_sign,
  input  logic             c_sign,
  input  logic             dp_valid,
  input  logic [WIDTH-1:0] dp_result,
  output logic             dp_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_special,
`ifdef FP_SPECIAL_INVALID_FLAG_EN
  output logic             out_invalid,
`endif
  input  logic             out_ready
);
  localparam logic [WIDTH-1:0] QNAN_C = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PINF_C = {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] NINF_C = {1'b1, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
  flags_t iss_flags, head;
  logic full, empty, push, pop;
  logic pz, cz, inf, invalid, is_nan, special;
  logic [WIDTH-1:0] res;
  logic out_valid_q, out_valid_d, out_special_q, out_special_d, out_invalid_q, out_invalid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  assign iss_flags = '{nan: setResultNaN, pinf: setResultPInf, ninf: setResultNInf,
                       a_pz: aIsPZero, a_nz: aIsNZero, b_pz: bIsPZero, b_nz: bIsNZero,
                       c_pz: cIsPZero, c_nz: cIsNZero, prod_sign: prod_sign, c_sign: c_sign};
  assign iss_ready = ~full;
  assign dp_ready  = ~empty & (~out_valid_q | out_ready);
  assign push      = iss_valid & iss_ready;
  assign pop       = dp_valid & dp_ready;
  fp_special_flag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(iss_flags), .dout(head), .full(full), .empty(empty)
  );
  // Invalid covers Inf-Inf and 0*Inf; a propagated input NaN is not an invalid operation.
  always_comb begin
    pz            = head.a_pz | head.a_nz | head.b_pz | head.b_nz;
    cz            = head.c_pz | head.c_nz;
    inf           = head.pinf | head.ninf;
    invalid       = (head.pinf & head.ninf) | (inf & pz);
    is_nan        = head.nan | invalid;
    special       = is_nan | inf | (pz & cz);
    res           = is_nan ? QNAN_C :
                    head.pinf ? PINF_C :
                    head.ninf ? NINF_C :
                    (pz & cz) ? {head.prod_sign & head.c_sign, {(WIDTH-1){1'b0}}} : dp_result;
    out_valid_d   = pop ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_result_d  = pop ? res : out_result_q;
    out_special_d = pop ? special : out_special_q;
    out_invalid_d = pop ? invalid : out_invalid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_special_q <= 1'b0;
      out_invalid_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_special_q <= out_special_d;
      out_invalid_q <= out_invalid_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_special = out_special_q;
`ifdef FP_SPECIAL_INVALID_FLAG_EN
  assign out_invalid = out_invalid_q;
`else
  logic unused_invalid;
  assign unused_invalid = out_invalid_q;
`endif
endmodule

// File: tb/tb_fp_special_result_merge.sv
// tb_fp_special_result_merge: table-driven vectors with an in-order scoreboard plus full/back-pressure/reset sequences.
module tb_fp_special_result_merge;
  logic clk = 1'b0;
  logic rst, iss_valid, iss_ready, dp_valid, dp_ready, out_valid, out_special, out_ready;
  logic [10:0] fl;
  logic [31:0] dp_result, out_result;
`ifdef FP_SPECIAL_INVALID_FLAG_EN
  logic out_invalid;
`endif
  always #5 clk = ~clk;

  fp_special_result_merge dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .aIsPZero(fl[7]), .aIsNZero(fl[6]), .bIsPZero(fl[5]), .bIsNZero(fl[4]),
    .cIsPZero(fl[3]), .cIsNZero(fl[2]), .setResultNaN(fl[10]), .setResultPInf(fl[9]),
    .setResultNInf(fl[8]), .prod_sign(fl[1]), .c_sign(fl[0]),
    .dp_valid(dp_valid), .dp_result(dp_result), .dp_ready(dp_ready),
    .out_valid(out_valid), .out_result(out_result), .out_special(out_special),
`ifdef FP_SPECIAL_INVALID_FLAG_EN
    .out_invalid(out_invalid),
`endif
    .out_ready(out_ready)
  );

  // flag order: nan pinf ninf apz anz bpz bnz cpz cnz prod_sign c_sign
  typedef struct {
    logic [10:0] fl;
    logic [31:0] dp;
    logic [31:0] res;
    logic        sp;
    logic        inv;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic        sp;
    logic        inv;
  } exp_t;

  vec_t tv [14];
  exp_t sb [$];
  exp_t e;
  int compared = 0, mismatched = 0;
  logic held = 1'b0, prev_sp;
  logic [31:0] prev_res;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    exp_t x;
    chk("iss_ready_before_issue", iss_ready, 1);
    x.res = v.res; x.sp = v.sp; x.inv = v.inv;
    sb.push_back(x);
    fl = v.fl; iss_valid = 1'b1;
    tick;
    iss_valid = 1'b0; fl = '0;
  endtask

  task automatic deliver(input logic [31:0] d, input bit tog);
    int n = 0;
    dp_result = d; dp_valid = 1'b1;
    if (tog) out_ready = ~out_ready;
    #1;
    while (!dp_ready && n < 50) begin
      @(posedge clk); #1;
      if (tog) out_ready = ~out_ready;
      #1;
      n++;
    end
    if (!dp_ready) chk("dp_ready_timeout", 0, 1);
    else tick;
    dp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held) begin
        chk("hold_result", out_result, prev_res);
        chk("hold_special", out_special, prev_sp);
      end
      if (out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("special", out_special, e.sp);
`ifdef FP_SPECIAL_INVALID_FLAG_EN
          chk("invalid", out_invalid, e.inv);
`endif
        end
      end
    end
    held = !rst && out_valid && !out_ready;
    prev_res = out_result;
    prev_sp = out_special;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; iss_valid = 1'b0; dp_valid = 1'b0; fl = '0; dp_result = '0; out_ready = 1'b1;
    tv[0]  = '{11'b1_0_0_0_0_0_0_0_0_0_0, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0};
    tv[1]  = '{11'b0_1_0_1_0_0_0_0_0_0_0, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b1};
    tv[2]  = '{11'b0_0_1_0_0_0_0_0_0_0_0, 32'h12345678, 32'hFF800000, 1'b1, 1'b0};
    tv[3]  = '{11'b0_0_0_0_0_0_1_0_1_1_1, 32'h3F800000, 32'h80000000, 1'b1, 1'b0};
    tv[4]  = '{11'b0_0_0_0_0_0_1_0_1_1_0, 32'hBF800000, 32'h00000000, 1'b1, 1'b0};
    tv[5]  = '{11'b0_0_0_0_0_0_0_0_0_0_0, 32'h40490FDB, 32'h40490FDB, 1'b0, 1'b0};
    tv[6]  = '{11'b0_1_1_0_0_0_0_0_0_0_0, 32'h00000001, 32'h7FC00000, 1'b1, 1'b1};
    tv[7]  = '{11'b0_1_0_0_0_0_0_0_0_0_0, 32'h00000002, 32'h7F800000, 1'b1, 1'b0};
    tv[8]  = '{11'b0_0_0_1_0_0_0_0_0_0_0, 32'h00000003, 32'h00000003, 1'b0, 1'b0};
    tv[9]  = '{11'b0_0_0_0_0_0_0_1_0_0_0, 32'hC0000000, 32'hC0000000, 1'b0, 1'b0};
    tv[10] = '{11'b0_0_0_0_1_0_0_1_0_0_0, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0};
    tv[11] = '{11'b1_0_0_1_0_0_0_0_1_0_0, 32'h11111111, 32'h7FC00000, 1'b1, 1'b0};
    tv[12] = '{11'b0_0_1_0_0_1_0_0_0_0_0, 32'h22222222, 32'h7FC00000, 1'b1, 1'b1};
    tv[13] = '{11'b0_0_0_0_0_1_0_1_0_0_1, 32'h33333333, 32'h00000000, 1'b1, 1'b0};
    tick; tick;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_special", out_special, 0);
    chk("reset_iss_ready", iss_ready, 1);
    chk("reset_dp_ready", dp_ready, 0);
    dp_valid = 1'b1; dp_result = 32'hDEADBEEF;
    tick;
    chk("empty_dp_ready", dp_ready, 0);
    dp_valid = 1'b0;
    chk("empty_no_output", out_valid, 0);
    for (int i = 0; i < 14; i++) begin
      issue(tv[i]);
      deliver(tv[i].dp, 1'b0);
      chk("latency_out_valid", out_valid, 1);
      tick;
    end
    chk("table_drained", sb.size(), 0);
    for (int i = 0; i < 4; i++) begin
      v = (i == 2) ? tv[0] : '{11'b0, 32'h10000000 + i, 32'h10000000 + i, 1'b0, 1'b0};
      issue(v);
    end
    chk("full_iss_ready", iss_ready, 0);
    chk("full_dp_ready", dp_ready, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) deliver((i == 2) ? tv[0].dp : 32'h10000000 + i, 1'b1);
    out_ready = 1'b1;
    tick; tick; tick;
    chk("backpressure_drained", sb.size(), 0);
    chk("backpressure_idle", out_valid, 0);
    issue(tv[0]); issue(tv[1]); issue(tv[2]);
    out_ready = 1'b0;
    deliver(tv[0].dp, 1'b0);
    chk("held_before_reset", out_valid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_result", out_result, 0);
    chk("midreset_dp_ready", dp_ready, 0);
    chk("midreset_iss_ready", iss_ready, 1);
    issue(tv[3]);
    deliver(tv[3].dp, 1'b0);
    chk("post_reset_latency", out_valid, 1);
    tick; tick;
    chk("post_reset_drained", sb.size(), 0);
    chk("post_reset_idle", dp_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
